// File: rtl/fma_ctrl_pkg.sv
// Shared encodings for the FMA issue controller: rounding modes,
// fflags bit positions and datapath flag positions.
package fma_ctrl_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4,
    RM_DYN = 3'd7
  } rm_e;

  // fflags layout {NV,DZ,OF,UF,NX}
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  // datapath flag layout {Invalid,Overflow,Underflow,Inexact}
  localparam int DPF_INVALID   = 3;
  localparam int DPF_OVERFLOW  = 2;
  localparam int DPF_UNDERFLOW = 1;
  localparam int DPF_INEXACT   = 0;

  // The FMA datapath never divides, so DZ is never raised.
  function automatic logic [4:0] map_dp_flags(input logic [3:0] f);
    logic [4:0] m;
    m            = '0;
    m[FF_NV]     = f[DPF_INVALID];
    m[FF_DZ]     = 1'b0;
    m[FF_OF]     = f[DPF_OVERFLOW];
    m[FF_UF]     = f[DPF_UNDERFLOW];
    m[FF_NX]     = f[DPF_INEXACT];
    return m;
  endfunction

endpackage

// File: rtl/fma_rsp_fifo.sv
// Response buffer: first-word-fall-through FIFO with occupancy count.
// The head entry is read combinationally so a response can be presented
// in the same cycle it becomes the oldest entry.
module fma_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_mem[r_wr_ptr] <= wr_data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (rd_en_i) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(wr_en_i) - CW'(rd_en_i);
    end
  end

  assign rd_data_o = r_mem[r_rd_ptr];
  assign count_o   = r_count;

endmodule

// File: rtl/fma_issue_ctrl.sv
// Issue controller for the single-precision FMA pipeline: round-robin
// arbitration of two requesters, dynamic rounding-mode resolution,
// credit-based in-flight tracking, in-order response buffering and
// fflags accrual. Define FMA_ISSUE_PERF_CNT_EN to add issue/stall counters.
module fma_issue_ctrl
  import fma_ctrl_pkg::*;
#(
  parameter int PARM_PIPE_DEPTH = 4,
  parameter int PARM_FIFO_DEPTH = 4,
  parameter int PARM_TAG        = 5,
  parameter int PARM_XLEN       = 32,
  parameter int PARM_RM         = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 Req0_valid_i,
  output logic                 Req0_ready_o,
  input  logic [PARM_RM-1:0]   Req0_rm_i,
  input  logic [PARM_TAG-1:0]  Req0_tag_i,
  input  logic                 Req1_valid_i,
  output logic                 Req1_ready_o,
  input  logic [PARM_RM-1:0]   Req1_rm_i,
  input  logic [PARM_TAG-1:0]  Req1_tag_i,
  input  logic                 Frm_we_i,
  input  logic [PARM_RM-1:0]   Frm_i,
  output logic [PARM_RM-1:0]   Frm_o,
  input  logic                 Fflags_clr_i,
  output logic [4:0]           Fflags_o,
  output logic                 Dp_valid_o,
  output logic [PARM_RM-1:0]   Dp_rm_o,
  input  logic [PARM_XLEN-1:0] Dp_result_i,
  input  logic [3:0]           Dp_flags_i,
  output logic                 Rsp_valid_o,
  input  logic                 Rsp_ready_i,
  output logic                 Rsp_src_o,
  output logic [PARM_TAG-1:0]  Rsp_tag_o,
  output logic [PARM_XLEN-1:0] Rsp_result_o,
  output logic [3:0]           Rsp_flags_o,
  output logic                 Rsp_illegal_o
`ifdef FMA_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]          Perf_issue_o,
  output logic [31:0]          Perf_stall_o
`endif
);

  localparam int RW = $clog2(PARM_FIFO_DEPTH + 1);
  localparam int PW = 3 + PARM_TAG;                      // {valid,kill,src,tag}
  localparam int FW = 1 + PARM_TAG + PARM_XLEN + 4 + 1;  // {src,tag,result,flags,kill}

  logic [RW-1:0]        r_res;
  logic                 r_rr_ptr;
  logic [PARM_RM-1:0]   r_frm;
  logic [4:0]           r_fflags;
  logic [PW-1:0]        r_pipe [PARM_PIPE_DEPTH];

  logic                 w_credit, w_gnt0, w_gnt1, w_issue, w_src, w_illegal;
  logic [PARM_TAG-1:0]  w_tag;
  logic [PARM_RM-1:0]   w_rm_sel, w_rm_res;
  logic [PW-1:0]        w_last;
  logic [FW-1:0]        w_fifo_wdata, w_fifo_rdata;
  logic [RW-1:0]        w_fifo_count;
  logic                 w_rsp_valid, w_hs, w_rsp_illegal, w_rsp_src;
  logic [PARM_TAG-1:0]  w_rsp_tag;
  logic [PARM_XLEN-1:0] w_rsp_result;
  logic [3:0]           w_rsp_flags;
  logic [4:0]           w_fflags_next;

  // Arbitration and rm resolution. Readies depend only on the valids and
  // registered state; the ready of one port never feeds the other.
  always_comb begin
    w_credit  = (r_res < RW'(PARM_FIFO_DEPTH));
    w_gnt0    = Req0_valid_i & (~Req1_valid_i | ~r_rr_ptr);
    w_gnt1    = Req1_valid_i & (~Req0_valid_i |  r_rr_ptr);
    w_issue   = (w_gnt0 | w_gnt1) & w_credit;
    w_src     = w_gnt1;
    w_tag     = w_gnt1 ? Req1_tag_i : Req0_tag_i;
    w_rm_sel  = w_gnt1 ? Req1_rm_i : Req0_rm_i;
    w_rm_res  = (w_rm_sel == RM_DYN) ? r_frm : w_rm_sel;
    w_illegal = (w_rm_res > RM_RMM);
  end

  assign Req0_ready_o = w_gnt0 & w_credit;
  assign Req1_ready_o = w_gnt1 & w_credit;
  // Killed ops still take a pipeline slot but are never launched.
  assign Dp_valid_o   = w_issue & ~w_illegal;
  assign Dp_rm_o      = Dp_valid_o ? w_rm_res : '0;

  // Credit counter, round-robin pointer and frm register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res    <= '0;
      r_rr_ptr <= 1'b0;
      r_frm    <= '0;
    end else begin
      r_res <= r_res + RW'(w_issue) - RW'(w_hs);
      if (Req0_valid_i && Req1_valid_i && w_issue) r_rr_ptr <= ~r_rr_ptr;
      if (Frm_we_i) r_frm <= Frm_i;
    end
  end

  // Tag pipeline that mirrors the fixed datapath latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PARM_PIPE_DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {w_issue, w_illegal, w_src, w_tag};
      for (int i = 1; i < PARM_PIPE_DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Last stage meets the datapath output; killed ops store zero result/flags.
  always_comb begin
    w_last       = r_pipe[PARM_PIPE_DEPTH-1];
    w_fifo_wdata = {w_last[PW-3], w_last[PARM_TAG-1:0],
                    w_last[PW-2] ? '0 : Dp_result_i,
                    w_last[PW-2] ? 4'b0 : Dp_flags_i,
                    w_last[PW-2]};
  end

  fma_rsp_fifo #(
    .DEPTH (PARM_FIFO_DEPTH),
    .WIDTH (FW)
  ) u_rsp_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (w_last[PW-1]),
    .wr_data_i (w_fifo_wdata),
    .rd_en_i   (w_hs),
    .rd_data_o (w_fifo_rdata),
    .count_o   (w_fifo_count)
  );

  // Unpack the head entry; outputs read as zero while the buffer is empty.
  always_comb begin
    w_rsp_valid   = (w_fifo_count != '0);
    w_hs          = w_rsp_valid & Rsp_ready_i;
    w_rsp_src     = w_fifo_rdata[FW-1];
    w_rsp_tag     = w_fifo_rdata[FW-2 -: PARM_TAG];
    w_rsp_result  = w_fifo_rdata[PARM_XLEN+4 -: PARM_XLEN];
    w_rsp_flags   = w_fifo_rdata[4:1];
    w_rsp_illegal = w_fifo_rdata[0];
  end

  assign Rsp_valid_o   = w_rsp_valid;
  assign Rsp_src_o     = w_rsp_valid & w_rsp_src;
  assign Rsp_tag_o     = w_rsp_valid ? w_rsp_tag : '0;
  assign Rsp_result_o  = w_rsp_valid ? w_rsp_result : '0;
  assign Rsp_flags_o   = w_rsp_valid ? w_rsp_flags : '0;
  assign Rsp_illegal_o = w_rsp_valid & w_rsp_illegal;

  // Flags accrue on handshake; a same-cycle clear keeps the new flags.
  always_comb begin
    w_fflags_next = Fflags_clr_i ? 5'b0 : r_fflags;
    if (w_hs && !w_rsp_illegal) w_fflags_next = w_fflags_next | map_dp_flags(w_rsp_flags);
  end

  // fflags register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_fflags <= '0;
    else         r_fflags <= w_fflags_next;
  end

  assign Frm_o    = r_frm;
  assign Fflags_o = r_fflags;

`ifdef FMA_ISSUE_PERF_CNT_EN
  logic [31:0] r_perf_issue, r_perf_stall;

  // Issue and stall counters; free-running with wrap, cleared with fflags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else if (Fflags_clr_i) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_issue) r_perf_issue <= r_perf_issue + 32'd1;
      if ((Req0_valid_i | Req1_valid_i) & ~w_credit) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign Perf_issue_o = r_perf_issue;
  assign Perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Directed + short random bench for fma_issue_ctrl with a scoreboard of
// expected responses and a cycle-level model of arbitration and credits.
module tb_fma_issue_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        Req0_valid_i, Req1_valid_i;
  logic        Req0_ready_o, Req1_ready_o;
  logic [2:0]  Req0_rm_i, Req1_rm_i;
  logic [4:0]  Req0_tag_i, Req1_tag_i;
  logic        Frm_we_i;
  logic [2:0]  Frm_i, Frm_o;
  logic        Fflags_clr_i;
  logic [4:0]  Fflags_o;
  logic        Dp_valid_o;
  logic [2:0]  Dp_rm_o;
  logic [31:0] Dp_result_i;
  logic [3:0]  Dp_flags_i;
  logic        Rsp_valid_o, Rsp_ready_i, Rsp_src_o, Rsp_illegal_o;
  logic [4:0]  Rsp_tag_o;
  logic [31:0] Rsp_result_o;
  logic [3:0]  Rsp_flags_o;

  fma_issue_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .Req0_valid_i(Req0_valid_i), .Req0_ready_o(Req0_ready_o),
    .Req0_rm_i(Req0_rm_i), .Req0_tag_i(Req0_tag_i),
    .Req1_valid_i(Req1_valid_i), .Req1_ready_o(Req1_ready_o),
    .Req1_rm_i(Req1_rm_i), .Req1_tag_i(Req1_tag_i),
    .Frm_we_i(Frm_we_i), .Frm_i(Frm_i), .Frm_o(Frm_o),
    .Fflags_clr_i(Fflags_clr_i), .Fflags_o(Fflags_o),
    .Dp_valid_o(Dp_valid_o), .Dp_rm_o(Dp_rm_o),
    .Dp_result_i(Dp_result_i), .Dp_flags_i(Dp_flags_i),
    .Rsp_valid_o(Rsp_valid_o), .Rsp_ready_i(Rsp_ready_i),
    .Rsp_src_o(Rsp_src_o), .Rsp_tag_o(Rsp_tag_o),
    .Rsp_result_o(Rsp_result_o), .Rsp_flags_o(Rsp_flags_o),
    .Rsp_illegal_o(Rsp_illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        src;
    logic [4:0]  tag;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        ill;
    logic [31:0] due;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0, n_total = 0, n_fail = 0;
  int          cyc = 0, op_id = 0, n_issued = 0;
  logic        m_ptr;
  int          m_res;
  logic [2:0]  m_frm;
  logic [4:0]  m_ff;
  logic [3:0]  nxt_flags;

  // Behavioural datapath: fixed 4-cycle delay of what the bench launches.
  logic [31:0] dl_in_res, dl_res [4];
  logic [3:0]  dl_in_flg, dl_flg [4];
  always @(posedge clk) begin
    dl_res[0] <= dl_in_res;
    dl_flg[0] <= dl_in_flg;
    for (int i = 1; i < 4; i++) begin
      dl_res[i] <= dl_res[i-1];
      dl_flg[i] <= dl_flg[i-1];
    end
  end
  assign Dp_result_i = dl_res[3];
  assign Dp_flags_i  = dl_flg[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] mapf(input logic [3:0] f);
    return {f[3], 1'b0, f[2], f[1], f[0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check combinational outputs mid-cycle against the model,
  // push/pop the scoreboard, then advance the model past the rising edge.
  task automatic cycle();
    logic credit, g0, g1, e0, e1, iss, ill, erv, hs, pop_ill;
    logic [2:0] rm, rr;
    logic [3:0] pop_flg;
    exp_t e;
    @(negedge clk);
    credit = (m_res < 4);
    g0  = Req0_valid_i & (!Req1_valid_i | (m_ptr == 1'b0));
    g1  = Req1_valid_i & (!Req0_valid_i | (m_ptr == 1'b1));
    e0  = g0 & credit;
    e1  = g1 & credit;
    iss = e0 | e1;
    rm  = e1 ? Req1_rm_i : Req0_rm_i;
    rr  = (rm == 3'd7) ? m_frm : rm;
    ill = (rr > 3'd4);
    chk("req0_ready", Req0_ready_o, e0);
    chk("req1_ready", Req1_ready_o, e1);
    chk("dp_valid", Dp_valid_o, iss & ~ill);
    chk("dp_rm", Dp_rm_o, (iss & ~ill) ? rr : 3'd0);
    chk("fflags", Fflags_o, m_ff);
    chk("frm", Frm_o, m_frm);
    dl_in_res = 32'hDEAD_0000 ^ cyc;
    dl_in_flg = 4'hF;
    if (iss) begin
      e.src = e1;
      e.tag = e1 ? Req1_tag_i : Req0_tag_i;
      e.ill = ill;
      e.res = ill ? 32'd0 : (32'h1000_0000 + op_id);
      e.flg = ill ? 4'd0 : nxt_flags;
      e.due = cyc + 5;
      if (!ill) begin
        dl_in_res = e.res;
        dl_in_flg = nxt_flags;
      end
      sb.push_back(e);
      op_id++;
      n_issued++;
      $display("cyc %0d issue src=%0d tag=%0d rm=%0d illegal=%0d", cyc, e1, e.tag, rr, ill);
    end
    erv = (sb.size() > 0) && (sb[0].due <= cyc);
    chk("rsp_valid", Rsp_valid_o, erv);
    pop_ill = 1'b0;
    pop_flg = 4'd0;
    if (erv) begin
      chk("rsp_src", Rsp_src_o, sb[0].src);
      chk("rsp_tag", Rsp_tag_o, sb[0].tag);
      chk("rsp_result", Rsp_result_o, sb[0].res);
      chk("rsp_flags", Rsp_flags_o, sb[0].flg);
      chk("rsp_illegal", Rsp_illegal_o, sb[0].ill);
      pop_ill = sb[0].ill;
      pop_flg = sb[0].flg;
    end
    hs = erv & Rsp_ready_i;
    if (hs) begin
      $display("cyc %0d response src=%0d tag=%0d result=%08h flags=%04b illegal=%0d",
               cyc, sb[0].src, sb[0].tag, sb[0].res, sb[0].flg, sb[0].ill);
      void'(sb.pop_front());
    end
    @(posedge clk);
    m_res = m_res + (iss ? 1 : 0) - (hs ? 1 : 0);
    if (Req0_valid_i && Req1_valid_i && iss) m_ptr = ~m_ptr;
    m_ff = (Fflags_clr_i ? 5'd0 : m_ff) | ((hs && !pop_ill) ? mapf(pop_flg) : 5'd0);
    if (Frm_we_i) m_frm = Frm_i;
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    Req0_valid_i = 0; Req1_valid_i = 0; Frm_we_i = 0; Fflags_clr_i = 0;
  endtask

  task automatic drain();
    int n = 0;
    idle_inputs();
    Rsp_ready_i = 1;
    while ((sb.size() > 0 || n < 2) && n < 40) begin
      cycle();
      n++;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr = 0; m_res = 0; m_frm = 3'd0; m_ff = 5'd0;
  endtask

  initial begin
    int base, n;
    rst_ni = 0; idle_inputs(); Rsp_ready_i = 0;
    Req0_rm_i = 0; Req1_rm_i = 0; Req0_tag_i = 0; Req1_tag_i = 0; Frm_i = 0;
    nxt_flags = 0; dl_in_res = 0; dl_in_flg = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", Rsp_valid_o, 1'b0);
    chk("reset_fflags", Fflags_o, 5'd0);
    chk("reset_frm", Frm_o, 3'd0);
    chk("reset_dp_valid", Dp_valid_o, 1'b0);
    chk("reset_rsp_tag", Rsp_tag_o, 5'd0);
    rst_ni = 1;
    @(posedge clk); #1;

    // Single op: Req0 rm=RTZ tag=5, datapath reports Inexact
    Req0_valid_i = 1; Req0_rm_i = 3'd1; Req0_tag_i = 5'd5; nxt_flags = 4'b0001;
    Rsp_ready_i = 1;
    cycle();
    drain();
    chk("single_fflags", Fflags_o, 5'b00001);

    // DYN: frm write in the same cycle is not yet visible, next cycle it is
    nxt_flags = 4'b0000;
    Req1_valid_i = 1; Req1_rm_i = 3'd7; Req1_tag_i = 5'd7; Frm_we_i = 1; Frm_i = 3'd3;
    cycle();
    Frm_we_i = 0;
    cycle();
    drain();
    chk("dyn_frm", Frm_o, 3'd3);

    // Illegal rm: killed op keeps its place, no flags accrue
    Req0_valid_i = 1; Req0_rm_i = 3'd5; Req0_tag_i = 5'd9; nxt_flags = 4'b1111;
    cycle();
    Req0_rm_i = 3'd2; Req0_tag_i = 5'd10; nxt_flags = 4'b0000;
    cycle();
    drain();
    chk("illegal_fflags", Fflags_o, 5'b00001);

    // Contention: both valid until six ops issued
    base = n_issued; n = 0;
    Req0_valid_i = 1; Req1_valid_i = 1; Req0_rm_i = 3'd0; Req1_rm_i = 3'd4;
    while (n_issued - base < 6 && n < 30) begin
      Req0_tag_i = 5'(cyc); Req1_tag_i = 5'(cyc + 16);
      nxt_flags = 4'(cyc);
      cycle();
      n++;
    end
    chk("contention_issues", n_issued - base, 6);
    drain();

    // Back-pressure: credits run out after four issues
    Rsp_ready_i = 0; Req0_valid_i = 1; Req1_valid_i = 1; nxt_flags = 4'b0000;
    base = n_issued;
    repeat (12) cycle();
    chk("bp_issue_count", n_issued - base, 4);
    chk("bp_ready0", Req0_ready_o, 1'b0);
    chk("bp_ready1", Req1_ready_o, 1'b0);
    base = n_issued;
    Rsp_ready_i = 1;
    cycle();
    Rsp_ready_i = 0;
    repeat (8) cycle();
    chk("bp_one_more", n_issued - base, 1);
    drain();

    // Clear/accrue race
    Fflags_clr_i = 1;
    cycle();
    Fflags_clr_i = 0;
    Req0_valid_i = 1; Req0_rm_i = 3'd0; Req0_tag_i = 5'd1; nxt_flags = 4'b1000;
    cycle();
    drain();
    chk("race_pre_fflags", Fflags_o, 5'b10000);
    Rsp_ready_i = 0;
    Req0_valid_i = 1; Req0_tag_i = 5'd2; nxt_flags = 4'b0100;
    cycle();
    Req0_valid_i = 0;
    n = 0;
    while (sb.size() > 0 && sb[0].due > cyc && n < 20) begin
      cycle();
      n++;
    end
    Fflags_clr_i = 1; Rsp_ready_i = 1;
    cycle();
    Fflags_clr_i = 0;
    chk("race_fflags", Fflags_o, 5'b00100);
    drain();

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      Req0_valid_i = 1'($urandom_range(0, 1));
      Req1_valid_i = 1'($urandom_range(0, 1));
      Req0_rm_i    = 3'($urandom_range(0, 7));
      Req1_rm_i    = 3'($urandom_range(0, 7));
      Req0_tag_i   = 5'($urandom_range(0, 31));
      Req1_tag_i   = 5'($urandom_range(0, 31));
      Frm_we_i     = ($urandom_range(0, 7) == 0);
      Frm_i        = 3'($urandom_range(0, 5));
      Rsp_ready_i  = ($urandom_range(0, 3) != 0);
      Fflags_clr_i = ($urandom_range(0, 15) == 0);
      nxt_flags    = 4'($urandom_range(0, 15));
      cycle();
    end
    drain();

    // Reset mid-operation drops everything in flight
    Frm_we_i = 1; Frm_i = 3'd2;
    Req0_valid_i = 1; Req1_valid_i = 1; Rsp_ready_i = 0; nxt_flags = 4'b0001;
    repeat (6) cycle();
    idle_inputs();
    rst_ni = 0;
    @(negedge clk);
    chk("midreset_rsp_valid", Rsp_valid_o, 1'b0);
    chk("midreset_frm", Frm_o, 3'd0);
    model_reset();
    @(posedge clk); #1;
    rst_ni = 1;
    Rsp_ready_i = 1;
    repeat (10) cycle();
    Req1_valid_i = 1; Req1_rm_i = 3'd7; Req1_tag_i = 5'd3; nxt_flags = 4'b0010;
    cycle();
    drain();
    chk("post_reset_fflags", Fflags_o, 5'b00010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
